// File: rtl/stopwatch_pkg.sv
// Shared FSM state encoding and BCD constants for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVF   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    OVF   = ST_OVF
  } state_e;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Next BCD value; anything at or above 9 folds back to 0.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    return (v >= BCD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch counter: advances when enabled with carry-in,
// flags done_c at 9 so the next decade can chain off it.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             cin,
  output logic [BCD_W-1:0] value,
  output logic             done_c
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en && cin) begin
      value <= bcd_inc(value);
    end else if (value > BCD_MAX) begin
      value <= '0;
    end
  end

  assign done_c = (value == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/overflow FSM, tick prescaler, cascaded BCD
// digits. Define STOPWATCH_LAP_HOLD_EN to add the lap display-hold input.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_stop,
  input  logic                      clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic                      lap,
`endif
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic                      running,
  output logic                      overflow,
  output logic                      tick
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  state_e             state_q;
  state_e             state_d;
  logic [PRESC_W-1:0] presc_q;
  logic [DIG_W-1:0]   live;
  logic [NUM_DIGITS-1:0] done_c;
  logic [NUM_DIGITS-1:0] cin_c;
  logic               all_nine_c;
  logic               cnt_en_c;
  logic               full_tick_c;

  // Tick decodes registered state only: last prescaler count while running.
  assign tick        = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign all_nine_c  = &done_c;
  assign cnt_en_c    = tick && !all_nine_c;
  assign full_tick_c = tick && all_nine_c;

  // Next-state logic; clear overrides every other command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN: begin
        if (full_tick_c)     state_d = OVF;
        else if (start_stop) state_d = PAUSE;
      end
      PAUSE:   if (start_stop) state_d = RUN;
      OVF:     state_d = OVF;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      running  <= (state_d == RUN);
      if (clear)            overflow <= 1'b0;
      else if (full_tick_c) overflow <= 1'b1;
    end
  end

  // Prescaler advances only in RUN, so a pause keeps the partial period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (state_q == RUN) begin
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  assign cin_c[0] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic inc_en_c;
    assign inc_en_c = cnt_en_c && cin_c[k];

    bcd_digit u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .en      (cnt_en_c),
      .cin     (cin_c[k]),
      .value   (live[4*k +: 4]),
      .done_c  (done_c[k])
    );

    if (k < NUM_DIGITS - 1) begin : g_carry
      assign cin_c[k+1] = done_c[k] && inc_en_c;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic             hold_q;
  logic [DIG_W-1:0] hold_val_q;

  // Lap toggles a frozen snapshot of the count; clear drops the hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= 1'b0;
      hold_val_q <= '0;
    end else if (clear) begin
      hold_q     <= 1'b0;
      hold_val_q <= '0;
    end else if (lap) begin
      hold_q <= !hold_q;
      if (!hold_q) hold_val_q <= live;
    end
  end

  assign digits = hold_q ? hold_val_q : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4, NUM_DIGITS=2; lap checks
// are included when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned NUM_DIGITS = 2;
  localparam int unsigned NVEC       = 28;

  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       clear;
  logic [7:0] digits;
  logic       running;
  logic       overflow;
  logic       tick;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap;
`endif

  int n_checks;
  int n_fail;

  typedef struct {
    logic       ss;
    logic       clr;
    logic [7:0] dig;
    logic       run;
    logic       tk;
    logic       ovf;
  } vec_t;

  vec_t vecs [NVEC];

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .overflow   (overflow),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given command pulses; outputs sampled 1 time unit after the edge.
  task automatic step(input logic ss, input logic clr);
    start_stop = ss;
    clear      = clr;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      chk("digit0_le_9", 32'(digits[3:0] <= 4'd9), 32'd1);
      chk("digit1_le_9", 32'(digits[7:4] <= 4'd9), 32'd1);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] dig, input logic run_e,
                          input logic tk, input logic ovf);
    chk({tag, "_digits"},   32'(digits),   32'(dig));
    chk({tag, "_running"},  32'(running),  32'(run_e));
    chk({tag, "_tick"},     32'(tick),     32'(tk));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic lap_step();
    lap = 1'b1;
    @(posedge clk);
    #1;
    lap = 1'b0;
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lap        = 1'b0;
`endif

    // Columns: start_stop, clear, expected digits, running, tick, overflow.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Start, three ticks, pause/resume mid-period, clear+start_stop collision.
    for (int i = 0; i < int'(NVEC); i++) begin
      step(vecs[i].ss, vecs[i].clr);
      chk_outs($sformatf("vec%0d", i), vecs[i].dig, vecs[i].run, vecs[i].tk, vecs[i].ovf);
    end

    // Decade carry: 09 -> 10 on a single edge.
    run(32);
    chk_outs("at_09", 8'h09, 1'b1, 1'b0, 1'b0);
    run(3);
    chk_outs("tick_at_09", 8'h09, 1'b1, 1'b1, 1'b0);
    run(1);
    chk_outs("carry_10", 8'h10, 1'b1, 1'b0, 1'b0);

    // Full scale: tick at 99 holds the count and enters overflow.
    run(356);
    chk_outs("at_99", 8'h99, 1'b1, 1'b0, 1'b0);
    run(3);
    chk_outs("tick_at_99", 8'h99, 1'b1, 1'b1, 1'b0);
    run(1);
    chk_outs("overflow", 8'h99, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk_outs("ovf_ss_ignored", 8'h99, 1'b0, 1'b0, 1'b1);
    run(8);
    chk_outs("ovf_hold", 8'h99, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_outs("ovf_clear", 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count; restart needs a fresh start_stop.
    step(1'b1, 1'b0);
    run(6);
    chk_outs("pre_async_reset", 8'h01, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run(5);
    chk_outs("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_outs("restart", 8'h00, 1'b1, 1'b0, 1'b0);
    run(3);
    chk_outs("restart_first_tick", 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk_outs("restart_clear", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_HOLD_EN
    // Lap freezes the display at 05 while eight more ticks accumulate.
    step(1'b1, 1'b0);
    run(20);
    chk_outs("lap_at_05", 8'h05, 1'b1, 1'b0, 1'b0);
    lap_step();
    chk("lap_hold_start", 32'(digits), 32'h05);
    run(31);
    chk("lap_hold_frozen", 32'(digits), 32'h05);
    chk("lap_still_running", 32'(running), 32'd1);
    lap_step();
    chk("lap_release", 32'(digits), 32'h13);
    lap_step();
    step(1'b0, 1'b1);
    chk("lap_clear_release", 32'(digits), 32'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
